audio_pwm_env: RTL
==================

Name: audio_pwm_env

Overview:
- Output stage downstream of the DDS sine generator in the simple-piano design.
- Takes the 10-bit offset-binary sine sample once per PWM period and applies an attack/sustain/release envelope gated by the key, plus a 3-bit volume shift.
- Drives a 1-bit PWM pin (buzzer/RC filter) at f_clk/2^PWM_BITS (11.72 kHz at 12 MHz).

Parameters:
DW, 10, sample width; offset binary, midscale 2^(DW-1)=512.
PWM_BITS, 10, PWM counter width; period 1024 clk.
ENV_BITS, 8, envelope width; full scale 255.
ATTACK_STEP, 8, envelope increment per period tick.
RELEASE_STEP, 2, envelope decrement per period tick.

Ports:
clk  in  1  system clock, 12 MHz.
rst  in  1  asynchronous reset, active high.
sample_in  in  10  sine sample from DDS, offset binary.
gate  in  1  key held; synchronous, debounced upstream.
volume  in  3  7 = full level; each step down = right shift by 1.
sample_req  out  1  one-cycle pulse; sample_in is captured on the next cycle.
pwm_out  out  1  PWM audio output, registered.
busy  out  1  high whenever the envelope FSM is not IDLE.

Behaviour:
Reset values (asynchronous, active high):
- cnt=0, duty=512, env=0, state=IDLE.
- pwm_out=0, sample_req=0, busy=0.
- Release of reset restarts the period at cnt=0.

Counter:
- cnt increments every clk and wraps 1023→0.

Per-period schedule:
- cnt==1020: sample_req=1 for exactly one cycle.
- cnt==1021: s_reg<=sample_in; envelope tick (FSM update, env update).
- cnt==1022: c = s_reg − 512 (signed 11-bit); p = (c × env) >>> 8 (arithmetic, floor); a = p >>> (7−volume).
- cnt==1023: duty_next = 512 + a, clamped to 0..1023.
- Edge leaving cnt==1023: duty <= duty_next. The new duty governs the period starting at cnt=0.
- volume is sampled at cnt==1022 only.
- Valid range of duty_next: 2..1021 at env=255, so the clamp never fires at legal values. Keep it anyway.

PWM output:
- pwm_out <= (cnt < duty), registered, so it lags cnt by one cycle.
- duty=0 → constant low. duty=1023 → high 1023 of every 1024 cycles.

Envelope FSM (evaluated only on the tick at cnt==1021; gate is level-sampled at that instant):
- IDLE: env=0. If gate=1 → ATTACK.
- ATTACK: env = min(env+ATTACK_STEP, 255). When the result is 255 → SUSTAIN. If gate=0 → RELEASE, with no increment that tick.
- SUSTAIN: env holds at 255. If gate=0 → RELEASE.
- RELEASE: env = max(env−RELEASE_STEP, 0). When the result is 0 → IDLE. If gate=1 → ATTACK from the current env, with no decrement that tick.

Rules:
- busy = (state != IDLE).
- Gate pulses that fall between ticks are ignored by design.
- Silence (env=0) gives duty=512, a 50% idle carrier with no audible tone.
- Mid-period volume or sample changes have no effect until the next schedule slot.
- Asynchronous reset mid-period aborts immediately, with no partial duty update.

Test Plan:
- Reset, gate=0, sample_in=1023 → pwm_out high exactly 512 of each 1024 clk; sample_req pulses once per 1024 clk at cnt=1020; busy=0.
- gate=1 held, ATTACK_STEP=8 → env 8,16,…,248,255 across 32 ticks; SUSTAIN on the 32nd tick; busy=1 from the first tick.
- SUSTAIN, volume=7 → sample_in=1023 gives duty=1021; sample_in=0 gives duty=2; sample_in=512 gives duty=512. Each is visible in the period after capture.
- SUSTAIN, volume=5 → sample_in=1023 gives duty=639 (509>>>2=127); sample_in=0 gives duty=384 (−510>>>2=−128).
- gate drops in SUSTAIN, RELEASE_STEP=2 → env 253,251,…,1,0 over 128 ticks, then IDLE with busy=0 and duty=512. Repeat, raising gate at env=101 → ATTACK resumes at 109.
- Assert rst at cnt=700 with duty=1021 → pwm_out, sample_req and busy go 0 at once, without waiting for clk. After release: cnt restarts at 0, duty=512, env=0.

Source files
------------

// File: rtl/audio_pwm_env.sv
// -----------------------------------------------------------------------------
// audio_pwm_env
//   Output stage behind the DDS sine generator. Once per PWM period it fetches
//   one offset-binary sample, scales it by an attack/sustain/release envelope
//   (gated by the key) and by a 3-bit volume shift, and turns the result into
//   the duty cycle of a single-bit PWM pin running at f_clk / 2^PWM_BITS.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active high
//   sample_in   in   DW-bit sine sample, offset binary (midscale = 2^(DW-1))
//   gate        in   key held; synchronous, debounced upstream
//   volume      in   3-bit volume, 7 = full, each step down halves the level
//   sample_req  out  one-cycle request pulse; sample_in is captured next cycle
//   pwm_out     out  registered PWM output
//   busy        out  high whenever the envelope FSM is not IDLE
//
// Sample handshake: sample_req is high for exactly one cycle per period
// (cnt == 2^PWM_BITS-4). The source must present a stable sample_in on the
// following cycle, where it is captured unconditionally; there is no stall.
// -----------------------------------------------------------------------------
module audio_pwm_env #(
    parameter int DW           = 10,
    parameter int PWM_BITS     = 10,
    parameter int ENV_BITS     = 8,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sample_in,
    input  logic          gate,
    input  logic [2:0]    volume,
    output logic          sample_req,
    output logic          pwm_out,
    output logic          busy
);

    // Per-period schedule slots, counted back from the end of the period.
    localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] REQ_SLOT  = CNT_MAX - PWM_BITS'(3);
    localparam logic [PWM_BITS-1:0] TICK_SLOT = CNT_MAX - PWM_BITS'(2);
    localparam logic [PWM_BITS-1:0] MATH_SLOT = CNT_MAX - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] PWM_MID   = {1'b1, {(PWM_BITS-1){1'b0}}};

    localparam logic [DW:0]         SMP_MID   = {2'b01, {(DW-1){1'b0}}};
    localparam logic [ENV_BITS-1:0] ENV_MAX   = {ENV_BITS{1'b1}};
    localparam logic [ENV_BITS:0]   ATT_INC   = (ENV_BITS+1)'(ATTACK_STEP);
    localparam logic [ENV_BITS:0]   REL_DEC   = (ENV_BITS+1)'(RELEASE_STEP);

    // Product and duty-sum widths with headroom for sign and carry.
    localparam int PW = DW + ENV_BITS + 2;
    localparam int SW = ((DW > PWM_BITS) ? DW : PWM_BITS) + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    logic [PWM_BITS-1:0] cnt_q;
    logic [DW-1:0]       s_q;
    logic [ENV_BITS-1:0] env_q, env_d;
    env_state_t          state_q, state_d;
    logic signed [DW:0]  a_q, a_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q;

    logic                tick;

    assign tick = (cnt_q == TICK_SLOT);

    // ---------------- envelope arithmetic (saturating) ----------------------
    logic [ENV_BITS:0]   env_sum;
    logic [ENV_BITS-1:0] env_up, env_dn;

    assign env_sum = {1'b0, env_q} + ATT_INC;
    assign env_up  = (env_sum >= {1'b0, ENV_MAX}) ? ENV_MAX : env_sum[ENV_BITS-1:0];
    assign env_dn  = ({1'b0, env_q} > REL_DEC) ? (env_q - REL_DEC[ENV_BITS-1:0]) : '0;

    // ---------------- envelope FSM, only advances on the tick ---------------
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    env_d = '0;
                    if (gate) begin
                        env_d   = env_up;
                        state_d = (env_up == ENV_MAX) ? SUSTAIN : ATTACK;
                    end
                end
                ATTACK: begin
                    // A released key turns around without taking a step.
                    if (!gate) begin
                        state_d = RELEASE;
                    end else begin
                        env_d = env_up;
                        if (env_up == ENV_MAX) begin
                            state_d = SUSTAIN;
                        end
                    end
                end
                SUSTAIN: begin
                    env_d = ENV_MAX;
                    if (!gate) begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    // A re-pressed key resumes attack from the current level.
                    if (gate) begin
                        state_d = ATTACK;
                    end else begin
                        env_d = env_dn;
                        if (env_dn == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    env_d   = '0;
                end
            endcase
        end
    end

    // ---------------- sample scaling ----------------------------------------
    // c = sample - midscale (signed), p = floor(c * env / 2^ENV_BITS),
    // a = floor(p / 2^(7 - volume)).
    logic signed [DW:0]   c_w;
    logic signed [PW-1:0] prod_w;
    logic signed [DW:0]   p_w;
    logic [2:0]           vol_sh;

    assign c_w    = $signed({1'b0, s_q} - SMP_MID);
    assign prod_w = $signed({{(PW-DW-1){c_w[DW]}}, c_w})
                  * $signed({{(PW-ENV_BITS){1'b0}}, env_q});
    assign p_w    = (DW+1)'(prod_w >>> ENV_BITS);
    assign vol_sh = 3'd7 - volume;
    assign a_d    = p_w >>> vol_sh;

    // ---------------- duty = midscale + a, clamped to the counter range -----
    logic signed [SW-1:0] sum_w;

    assign sum_w = $signed(SW'(PWM_MID)) + $signed({{(SW-DW-1){a_q[DW]}}, a_q});

    always_comb begin
        duty_d = sum_w[PWM_BITS-1:0];
        if (sum_w < 0) begin
            duty_d = '0;
        end else if (sum_w > $signed(SW'(CNT_MAX))) begin
            duty_d = CNT_MAX;
        end
    end

    // ---------------- state registers ---------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            s_q     <= SMP_MID[DW-1:0];
            env_q   <= '0;
            state_q <= IDLE;
            a_q     <= '0;
            duty_q  <= PWM_MID;
            pwm_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + PWM_BITS'(1);
            pwm_q   <= (cnt_q < duty_q);
            state_q <= state_d;
            env_q   <= env_d;
            if (tick) begin
                s_q <= sample_in;
            end
            // volume is only looked at here.
            if (cnt_q == MATH_SLOT) begin
                a_q <= a_d;
            end
            // New duty takes effect exactly at the period boundary.
            if (cnt_q == CNT_MAX) begin
                duty_q <= duty_d;
            end
        end
    end

    assign sample_req = (cnt_q == REQ_SLOT);
    assign pwm_out    = pwm_q;
    assign busy       = (state_q != IDLE);

endmodule
